// File: rtl/layer2_dense_seq_pkg.sv
// Shared types and constants for the layer-2 dense stage: FSM states,
// lane/sum widths and the requantisation saturation bounds.
package layer2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LANES   = 8;
  localparam int LANE_W  = 8;
  localparam int PROD_W  = 2 * LANE_W;
  localparam int SUM_W   = 19;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

endpackage

// File: rtl/layer2_dense_seq_dot_lane_sum.sv
// Combinational 8-lane signed dot product: eight 8x8 products reduced
// through a three-level adder tree into a 19-bit signed sum.
module dot_lane_sum
  import layer2_pkg::*;
(
  input  logic        [LANES*LANE_W-1:0] a,
  input  logic        [LANES*LANE_W-1:0] b,
  output logic signed [SUM_W-1:0]        sum
);

  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [SUM_W-1:0]  lvl1 [LANES/2];
  logic signed [SUM_W-1:0]  lvl2 [LANES/4];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = $signed(a[i*LANE_W +: LANE_W]) * $signed(b[i*LANE_W +: LANE_W]);
    end
  end

  // 19 bits hold 8 * (-128 * -128) = 131072 without overflow.
  always_comb begin
    for (int j = 0; j < LANES/2; j++) begin
      lvl1[j] = SUM_W'(prod[2*j]) + SUM_W'(prod[2*j+1]);
    end
    for (int j = 0; j < LANES/4; j++) begin
      lvl2[j] = lvl1[2*j] + lvl1[2*j+1];
    end
    sum = lvl2[0] + lvl2[1];
  end

endmodule

// File: rtl/layer2_dense_seq.sv
// Layer-2 dense stage: captures the layer-1 vector, streams one weight word per
// neuron from a 1-cycle BRAM, and requantises each dot product into dout_o.
module layer2_dense_seq
  import layer2_pkg::*;
#(
  parameter int IN_NUM     = 8,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_NUM    = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int SHIFT      = 7,
  parameter int RELU       = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [IN_NUM*DATA_WIDTH-1:0]     din_i,
  output logic                             w_en_o,
  output logic [ADDR_WIDTH-1:0]            w_addr_o,
  input  logic [IN_NUM*DATA_WIDTH-1:0]     w_data_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [OUT_NUM*DATA_WIDTH-1:0]    dout_o,
  output logic                             ovf_o
);

  localparam int VEC_W = IN_NUM * DATA_WIDTH;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(SAT_MAX);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(SAT_MIN);

  state_t                     state, state_n;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic                       drain_q;
  logic [VEC_W-1:0]           cap_q;
  logic                       accept;
  logic                       last_addr;
  logic                       ovf_q;

  logic                       rd_vld_q;
  logic [ADDR_WIDTH-1:0]      rd_idx_q;
  logic                       sum_vld_q;
  logic [ADDR_WIDTH-1:0]      sum_idx_q;
  logic signed [SUM_W-1:0]    sum_d, sum_q;
  logic signed [SUM_W-1:0]    shifted;
  logic [DATA_WIDTH-1:0]      q_lane;
  logic [OUT_NUM*DATA_WIDTH-1:0] dout_q;

  assign last_addr = (addr_q == ADDR_WIDTH'(OUT_NUM - 1));
  assign w_addr_o  = addr_q;
  assign dout_o    = dout_q;
  assign ovf_o     = ovf_q;

  always_comb begin
    state_n = state;
    w_en_o  = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: begin
        w_en_o = 1'b1;
        busy_o = 1'b1;
        if (last_addr) state_n = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (drain_q) state_n = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        // A start coinciding with done chains straight into the next run.
        if (start_i) begin
          accept  = 1'b1;
          state_n = FETCH;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      drain_q <= 1'b0;
      cap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      drain_q <= (state == DRAIN) ? ~drain_q : 1'b0;
      if (accept) begin
        cap_q  <= din_i;
        addr_q <= '0;
      end else if (state == FETCH && !last_addr) begin
        addr_q <= addr_q + 1'b1;
      end
      if (busy_o && start_i) ovf_q <= 1'b1;
    end
  end

  dot_lane_sum u_dot (
    .a   (cap_q),
    .b   (w_data_i),
    .sum (sum_d)
  );

  // Arithmetic shift floors toward minus infinity, then clamp and optional ReLU.
  always_comb begin
    shifted = sum_q >>> SHIFT;
    if (shifted > SAT_HI) begin
      q_lane = DATA_WIDTH'(SAT_MAX);
    end else if (shifted < SAT_LO) begin
      q_lane = DATA_WIDTH'(SAT_MIN);
    end else begin
      q_lane = shifted[DATA_WIDTH-1:0];
    end
    if (RELU != 0 && q_lane[DATA_WIDTH-1]) q_lane = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      sum_vld_q <= 1'b0;
      sum_idx_q <= '0;
      sum_q     <= '0;
      dout_q    <= '0;
    end else begin
      rd_vld_q  <= w_en_o;
      rd_idx_q  <= addr_q;
      sum_vld_q <= rd_vld_q;
      sum_idx_q <= rd_idx_q;
      if (rd_vld_q) sum_q <= sum_d;
      if (sum_vld_q) dout_q[sum_idx_q*DATA_WIDTH +: DATA_WIDTH] <= q_lane;
    end
  end

endmodule

// File: tb/tb_layer2_dense_seq.sv
// Self-checking bench: a RELU=1 and a RELU=0 instance share stimulus and a
// weight memory; results are compared against an integer reference model.
module tb_layer2_dense_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] din;
  logic [63:0] mem [4];

  int tests_run    = 0;
  int tests_failed = 0;

  logic        a_w_en, b_w_en;
  logic [1:0]  a_w_addr, b_w_addr;
  logic [63:0] a_w_data, b_w_data;
  logic        a_busy, b_busy, a_done, b_done, a_ovf, b_ovf;
  logic [31:0] a_dout, b_dout;

  always #5 clk = ~clk;

  layer2_dense_seq #(.RELU(1)) dut_relu (
    .clk_i(clk), .rst_i(rst), .start_i(start), .din_i(din),
    .w_en_o(a_w_en), .w_addr_o(a_w_addr), .w_data_i(a_w_data),
    .busy_o(a_busy), .done_o(a_done), .dout_o(a_dout), .ovf_o(a_ovf)
  );

  layer2_dense_seq #(.RELU(0)) dut_lin (
    .clk_i(clk), .rst_i(rst), .start_i(start), .din_i(din),
    .w_en_o(b_w_en), .w_addr_o(b_w_addr), .w_data_i(b_w_data),
    .busy_o(b_busy), .done_o(b_done), .dout_o(b_dout), .ovf_o(b_ovf)
  );

  always @(posedge clk) if (a_w_en) a_w_data <= mem[a_w_addr];
  always @(posedge clk) if (b_w_en) b_w_data <= mem[b_w_addr];

  // Integer reference: floor division by 128, clamp to a signed byte, optional ReLU.
  function automatic logic [31:0] modelDout(input logic [63:0] d, input bit relu);
    logic [31:0] r;
    int s, q;
    byte x, y;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = 0;
      for (int i = 0; i < 8; i++) begin
        x = d[8*i +: 8];
        y = mem[k][8*i +: 8];
        s = s + int'(x) * int'(y);
      end
      q = (s >= 0) ? s / 128 : -((-s + 127) / 128);
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      if (relu && q < 0) q = 0;
      r[8*k +: 8] = q[7:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " w_en"},  a_w_en,   0);
    checkOutput({tag, " addr"},  a_w_addr, 0);
    checkOutput({tag, " busy"},  a_busy,   0);
    checkOutput({tag, " done"},  a_done,   0);
    checkOutput({tag, " dout"},  a_dout,   0);
    checkOutput({tag, " ovf"},   a_ovf,    0);
    checkOutput({tag, " b_w_en"}, b_w_en,  0);
    checkOutput({tag, " b_dout"}, b_dout,  0);
    checkOutput({tag, " b_done"}, b_done,  0);
  endtask

  // Called at a negedge; start is presented in that cycle (t0).
  task automatic applyStimulus(input logic [63:0] d);
    start = 1'b1;
    din   = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walks cycles t0+1..t0+7 checking handshake timing; returns in the done cycle.
  task automatic monitorRun(input string name, input int ovr_cycle,
                            input logic [63:0] ovr_din, input bit ovf_before);
    bit exp_ovf;
    for (int c = 1; c <= 7; c++) begin
      exp_ovf = ovf_before || (ovr_cycle > 0 && c > ovr_cycle);
      checkOutput($sformatf("%s w_en c%0d", name, c), a_w_en, (c <= 4));
      if (c <= 4) checkOutput($sformatf("%s addr c%0d", name, c), a_w_addr, c - 1);
      checkOutput($sformatf("%s busy c%0d", name, c), a_busy, (c <= 6));
      checkOutput($sformatf("%s done c%0d", name, c), a_done, (c == 7));
      checkOutput($sformatf("%s b_done c%0d", name, c), b_done, (c == 7));
      checkOutput($sformatf("%s ovf c%0d", name, c), a_ovf, exp_ovf);
      if (ovr_cycle > 0 && c == ovr_cycle) begin
        start = 1'b1;
        din   = ovr_din;
      end else if (ovr_cycle > 0 && c == ovr_cycle + 1) begin
        start = 1'b0;
      end
      if (c < 7) @(negedge clk);
    end
  endtask

  task automatic checkResult(input string name, input logic [63:0] d);
    checkOutput({name, " dout relu"}, a_dout, modelDout(d, 1'b1));
    checkOutput({name, " dout lin"},  b_dout, modelDout(d, 1'b0));
  endtask

  task automatic loadRandomWeights();
    for (int k = 0; k < 4; k++) mem[k] = {$urandom, $urandom};
  endtask

  initial begin
    logic [63:0] d1, d2;
    rst   = 1'b1;
    start = 1'b0;
    din   = '0;
    for (int k = 0; k < 4; k++) mem[k] = '0;
    repeat (2) @(negedge clk);
    checkIdleZero("reset");
    rst = 1'b0;
    @(negedge clk);

    mem[0] = {8{8'h10}};
    mem[1] = {8{8'h7F}};
    mem[2] = {8{8'h80}};
    mem[3] = {8{8'h00}};
    d1 = 64'h0101010101010101;
    applyStimulus(d1);
    monitorRun("basic", 0, '0, 1'b0);
    checkOutput("basic relu const", a_dout, 32'h00000701);
    checkOutput("basic lin const",  b_dout, 32'h00F80701);
    checkResult("basic", d1);
    @(negedge clk);

    for (int k = 0; k < 4; k++) mem[k] = {8{8'h80}};
    applyStimulus({8{8'h7F}});
    monitorRun("satlo", 0, '0, 1'b0);
    checkOutput("satlo lin const",  b_dout, 32'h80808080);
    checkOutput("satlo relu const", a_dout, 32'h00000000);
    @(negedge clk);

    for (int k = 0; k < 4; k++) mem[k] = {8{8'h7F}};
    applyStimulus({8{8'h7F}});
    monitorRun("sathi", 0, '0, 1'b0);
    checkOutput("sathi lin const",  b_dout, 32'h7F7F7F7F);
    checkOutput("sathi relu const", a_dout, 32'h7F7F7F7F);
    @(negedge clk);

    mem[0] = 64'h00000000000000FF;
    for (int k = 1; k < 4; k++) mem[k] = '0;
    applyStimulus(64'h0000000000000001);
    monitorRun("floor", 0, '0, 1'b0);
    checkOutput("floor lin const",  b_dout, 32'h000000FF);
    checkOutput("floor relu const", a_dout, 32'h00000000);
    @(negedge clk);

    loadRandomWeights();
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    applyStimulus(d1);
    monitorRun("b2b1", 0, '0, 1'b0);
    checkResult("b2b1", d1);
    applyStimulus(d2);
    monitorRun("b2b2", 0, '0, 1'b0);
    checkResult("b2b2", d2);
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      loadRandomWeights();
      d1 = {$urandom, $urandom};
      applyStimulus(d1);
      monitorRun($sformatf("rand%0d", r), 0, '0, 1'b0);
      checkResult($sformatf("rand%0d", r), d1);
      @(negedge clk);
    end

    loadRandomWeights();
    d1 = {$urandom, $urandom};
    d2 = ~d1;
    applyStimulus(d1);
    monitorRun("ovr", 3, d2, 1'b0);
    checkResult("ovr", d1);
    @(negedge clk);
    d2 = {$urandom, $urandom};
    applyStimulus(d2);
    monitorRun("sticky", 0, '0, 1'b1);
    checkResult("sticky", d2);
    @(negedge clk);

    loadRandomWeights();
    applyStimulus({$urandom, $urandom});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkIdleZero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput($sformatf("postrst done c%0d", c), a_done, 0);
      checkOutput($sformatf("postrst b_done c%0d", c), b_done, 0);
    end

    d1 = {$urandom, $urandom};
    applyStimulus(d1);
    monitorRun("fresh", 0, '0, 1'b0);
    checkResult("fresh", d1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/layer2_dense_seq.md
Name: layer2_dense_seq

Overview:
- Layer-2 stage that sits directly downstream of the layer-1 processing unit.
- On layer-1 completion, captures the packed 8-lane signed layer-1 result vector.
- Streams OUT_NUM weight words from an external weight BRAM (1-cycle read latency) and computes one 8-lane dot product per cycle.
- Requantises each sum to 8 bits with shift, saturate and optional ReLU, packs the results and signals done.

Parameters:
- IN_NUM, 8, input lanes per vector (fixed 8 for this revision)
- DATA_WIDTH, 8, bits per lane, signed
- OUT_NUM, 4, output neurons; also the number of weight words read per run
- ADDR_WIDTH, 2, weight BRAM address width; must be at least clog2(OUT_NUM)
- SHIFT, 7, arithmetic right shift applied to each dot-product sum
- RELU, 1, 1 means negative requantised results become 0

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse from layer-1 done; din_i is valid in the same cycle
- din_i  in  64  layer-1 result; lane i = din_i[8i+7:8i], signed
- w_en_o  out  1  weight BRAM read enable
- w_addr_o  out  ADDR_WIDTH  weight BRAM address (neuron index)
- w_data_i  in  64  weight word, lane i = [8i+7:8i], signed; valid one cycle after w_en_o
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse; every dout_o lane is from the current run
- dout_o  out  OUT_NUM*8  result; neuron k = [8k+7:8k], signed
- ovf_o  out  1  sticky flag: start_i arrived while busy

Behaviour:
- Reset (async, rst_i=1) forces: state IDLE; w_en_o=0, w_addr_o=0, busy_o=0, done_o=0, dout_o=0, ovf_o=0; capture register cleared; pipeline valids cleared.
- A reset asserted mid-run aborts the run; no done_o is produced.
- State machine: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
- IDLE: start_i=1 latches din_i into the capture register and moves to FETCH.
- FETCH: w_en_o=1 with w_addr_o = 0, 1, …, OUT_NUM-1 on consecutive cycles. After the last address, moves to DRAIN.
- DRAIN: waits 2 cycles for the pipeline to empty, then moves to DONE.
- DONE: done_o=1 for exactly one cycle, then returns to IDLE. start_i sampled in the DONE cycle is accepted as a new start (back-to-back runs).
- Timing, with start_i sampled at cycle t0:
  - w_en_o/addr k asserted in cycle t0+1+k.
  - w_data_i for neuron k arrives in cycle t0+2+k.
  - Sum register holds neuron k in cycle t0+3+k.
  - dout_o lane k is visible from cycle t0+4+k.
  - done_o is high in cycle t0+OUT_NUM+3; for OUT_NUM=4 that is t0+7.
  - busy_o is high from t0+1 through t0+OUT_NUM+2 and low in the done cycle.
- Arithmetic:
  - Each product is signed 8x8 -> 16 bits.
  - Eight products are summed into a 19-bit signed value; no overflow is possible.
  - The sum is arithmetic-shifted right by SHIFT (floor rounding, so -1 gives -1).
  - The result saturates to [-128, 127].
  - If RELU=1, values below 0 become 0.
- dout_o lanes not yet rewritten in a run keep their previous-run values. dout_o is coherent only at done_o and thereafter, until the next start.
- start_i while busy_o=1 (FETCH or DRAIN) is ignored: the capture register is unchanged and ovf_o is set. ovf_o is cleared only by reset.
- w_addr_o holds its last value when w_en_o=0.

Decomposition:
- Package layer2_pkg holds:
  - state encoding (IDLE, FETCH, DRAIN, DONE);
  - LANE_W=8, SUM_W=19 and the lane count;
  - the saturation bounds SAT_MAX=127 and SAT_MIN=-128.
- Sub-module dot_lane_sum (combinational): 8-lane signed multiply and 19-bit adder tree. Takes two 64-bit inputs, outputs a 19-bit sum.
- The top level owns the FSM, the capture and sum registers, requantisation and packing.

Test Plan:
- Basic run: RELU=1, din_i=64'h0101010101010101, weights {addr0=8x8'h10, addr1=8x8'h7F, addr2=8x8'h80, addr3=8x8'h00}, start at t0 -> dout_o lanes {1, 7, 0, 0}; done_o only at t0+7; w_en_o high exactly in t0+1..t0+4 with addresses 0..3.
- RELU=0 negative path: same stimulus -> lane2=8'hF8 (-8). Then din=8x8'h7F with w=8x8'h80 -> -128 (saturated). Then din=8x8'h7F with w=8x8'h7F -> 127 (saturated).
- Floor rounding: RELU=0, din lane0=1 and w lane0=-1, all other lanes 0 -> sum -1 -> dout lane -1 (8'hFF).
- Back-to-back: second start_i in the done cycle with new din_i -> second done_o exactly 7 cycles later; ovf_o stays 0.
- Overrun: start_i pulsed at t0+3 with different din_i -> ignored, results unchanged, ovf_o=1 from t0+4 and sticky until reset.
- Reset mid-run: assert rst_i at t0+3 -> all outputs 0 immediately (asynchronous), no done_o. After release, a fresh start completes normally.
